output_module: RTL and testbench
================================

Name: output_module

Overview:
Display back-end of the calendar. It consumes the edit controls produced by the input side (set, select, mode_ampm, clock_4Hz) and the binary time, date and d-day field values. It converts the active page to BCD with one shared sequential double-dabble engine and drives eight registered active-low seven-segment digits (hex7..hex0). While a field is selected for editing, that field blinks.

Parameters:
CONV_BITS, 7, width of each binary field; values 0-99 are valid.
PAIRS, 4, digit pairs per page; fixed at 4, not for override.

Ports:
clock_50MHz  input  1  system clock
reset  input  1  asynchronous, active-low reset
clock_4Hz  input  1  blink square wave, asynchronous to this block; synchronised internally
set  input  3  page/edit enables: [0] clock, [1] date, [2] dset
select  input  13  field selects: [2:0] clock, [7:3] date, [12:8] dset
mode_ampm  input  1  1 = show AM/PM marker
pm  input  1  1 = PM (used only when mode_ampm=1)
clock_fields  input  21  [20:14] hour, [13:7] minute, [6:0] second
date_fields  input  28  pair3..pair0, 7 bits each, pair3 in [27:21]
dset_fields  input  28  same packing as date_fields
hex7..hex0  output  7 each  active-low segments, bit order {g,f,e,d,c,b,a}
refresh_done  output  1  one-cycle pulse when all 4 pairs are stored

Behaviour:
- Reset: hex* = 7'h7F (blank); refresh_done = 0; FSM in LOAD; pair index = 0; blink sync flops = 0.
- Page selection, priority set[2] > set[1] > otherwise clock page (also selected when set = 000).
- Pair-to-digit mapping: pairN drives hex(2N+1) (tens digit) and hex(2N) (units digit).
  - Clock page: pair2 = hour, pair1 = minute, pair0 = second.
  - Clock page pair3: mode_ampm=1 → hex7 = 'A' (08) or 'P' (0C) per pm, hex6 blank; mode_ampm=0 → both blank.
  - Date/dset pages: pair k = field k.
- FSM loops continuously: LOAD (1 cycle) → SHIFT (7 cycles) → STORE (1 cycle) → LOAD for the next pair. One pair takes 9 cycles; a full refresh takes 36 cycles.
  - LOAD: capture field[pair] and clear the BCD accumulator.
  - SHIFT: each cycle, add 3 to any BCD nibble ≥5, then shift left by 1.
  - STORE: write the decoded pair into the digit registers and advance the index (3 → 0). Pulse refresh_done in the cycle the index wraps 3 → 0.
- Pair3 of the clock page still takes its 9-cycle slot; its STORE writes the AM/PM marker.
- Field value > 99 → both digits '-' (3F). No leading-zero suppression.
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Page change, detected as the registered page differing from the new page:
  - all stored digits blank on the next cycle;
  - the FSM aborts and restarts at LOAD with pair0;
  - valid digits appear at most 36 cycles later.
- Field values are sampled only at LOAD. A change mid-conversion takes effect on that pair's next slot.
- Blink:
  - clock_4Hz passes through a 2-flop synchroniser (blk).
  - A digit pair is blanked when all three hold: its page's set bit = 1, the pair's select bit = 1, and blk = 0.
  - Clock select map: [0] = pair2, [1] = pair1, [2] = pair0.
  - Date select map: [3] = pair3, [4] = pair2, [5] = pair1, [6] = pair0, [7] = all eight digits.
  - Dset select map: [12:8] in the same order as date.
  - The AM/PM marker blinks with the hour field.
  - Blink masking is applied in the registered output stage: 1 cycle after blk changes, 3 cycles after a clock_4Hz edge.
- No blink when the page's set bit = 0, even if select bits are set.
- Asynchronous reset asserted mid-conversion blanks outputs immediately. After release, the refresh restarts from pair0.

Test Plan:
- Reset then release; clock page, hour=12, minute=34, second=56, mode_ampm=0 → hex5..hex0 = 79, 24, 30, 19, 12, 02 by cycle 37; hex7 = hex6 = 7F; refresh_done pulses once every 36 cycles.
- second=100 → hex1 = hex0 = 3F after the next refresh; second=0 → 40, 40.
- set=001, select=13'b0_0000_0000_0010, clock_4Hz held low → hex3 = hex2 = 7F within 3 cycles; clock_4Hz high → 30, 19 restored; all other digits never blank.
- Mid-refresh, set 001→010 with date_fields = {20, 24, 7, 15} → all hex = 7F next cycle; within 36 cycles hex7..hex0 = 24, 40, 24, 19, 40, 78, 79, 12.
- mode_ampm=1, pm=1 → hex7 = 0C, hex6 = 7F; pm=0 → hex7 = 08. With set=001 and select[0]=1 at blk=0 → hex7 and hex5, hex4 = 7F.
- set=010, select[7]=1, blk low → all eight digits 7F. Assert reset mid-SHIFT → outputs 7F asynchronously; after release, first refresh_done arrives 36 cycles later.

Source files
------------

// File: rtl/output_module.sv
// output_module: calendar display back-end.
// One shared double-dabble engine refreshes eight blinking 7-segment digits.
module output_module #(
    parameter int CONV_BITS = 7,
    parameter int PAIRS     = 4
) (
    input  logic                       clock_50MHz,
    input  logic                       reset,
    input  logic                       clock_4Hz,
    input  logic [2:0]                 set,
    input  logic [12:0]                select,
    input  logic                       mode_ampm,
    input  logic                       pm,
    input  logic [3*CONV_BITS-1:0]     clock_fields,
    input  logic [PAIRS*CONV_BITS-1:0] date_fields,
    input  logic [PAIRS*CONV_BITS-1:0] dset_fields,
    output logic [6:0]                 hex7,
    output logic [6:0]                 hex6,
    output logic [6:0]                 hex5,
    output logic [6:0]                 hex4,
    output logic [6:0]                 hex3,
    output logic [6:0]                 hex2,
    output logic [6:0]                 hex1,
    output logic [6:0]                 hex0,
    output logic                       refresh_done
);

    localparam int IW = $clog2(PAIRS);
    localparam int CW = $clog2(CONV_BITS);
    localparam logic [IW-1:0] LAST    = IW'(PAIRS - 1);
    localparam logic [CW-1:0] SH_LAST = CW'(CONV_BITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_P     = 7'h0C;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    typedef enum logic [1:0] {
        PG_CLOCK,
        PG_DATE,
        PG_DSET
    } page_t;

    state_t               r_state;
    state_t               w_next;
    page_t                r_page;
    page_t                w_page;
    logic                 w_chg;
    logic                 r_blk_s1;
    logic                 r_blk;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_load_idx;
    logic [CW-1:0]        r_cnt;
    logic [CONV_BITS-1:0] r_val;
    logic [CONV_BITS-1:0] r_sh;
    logic [CONV_BITS-1:0] w_field;
    logic [7:0]           r_bcd;
    logic [7:0]           w_adj;
    logic [7:0][6:0]      r_dig;
    logic [7:0][6:0]      r_hex;
    logic [6:0]           w_tens;
    logic [6:0]           w_units;
    logic                 w_blink_en;
    logic [3:0]           w_pair_blink;
    logic                 r_done;

    function automatic logic [3:0] f_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_comb begin
        w_page = PG_CLOCK;
        if (set[2])
            w_page = PG_DSET;
        else if (set[1])
            w_page = PG_DATE;
    end

    assign w_chg = (r_page != w_page);

    // A page change acts as the LOAD of pair0 of the new page.
    always_comb begin
        w_load_idx = w_chg ? '0 : r_idx;
        w_field    = '0;
        case (w_page)
            PG_CLOCK: begin
                if (w_load_idx != LAST)
                    w_field = clock_fields[w_load_idx*CONV_BITS +: CONV_BITS];
            end
            PG_DATE: w_field = date_fields[w_load_idx*CONV_BITS +: CONV_BITS];
            PG_DSET: w_field = dset_fields[w_load_idx*CONV_BITS +: CONV_BITS];
            default: w_field = '0;
        endcase
    end

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset)
            r_state <= S_LOAD;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_chg) begin
            w_next = S_SHIFT;
        end else begin
            unique case (r_state)
                S_LOAD:  w_next = S_SHIFT;
                S_SHIFT: w_next = (r_cnt == SH_LAST) ? S_STORE : S_SHIFT;
                S_STORE: w_next = S_LOAD;
                default: w_next = S_LOAD;
            endcase
        end
    end

    assign w_adj = {f_adj(r_bcd[7:4]), f_adj(r_bcd[3:0])};

    always_comb begin
        w_tens  = f_seg(r_bcd[7:4]);
        w_units = f_seg(r_bcd[3:0]);
        if (r_page == PG_CLOCK && r_idx == LAST) begin
            w_tens  = mode_ampm ? (pm ? SEG_P : SEG_A) : SEG_BLANK;
            w_units = SEG_BLANK;
        end else if (r_val > CONV_BITS'(99)) begin
            w_tens  = SEG_DASH;
            w_units = SEG_DASH;
        end
    end

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset) begin
            r_page <= PG_CLOCK;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_val  <= '0;
            r_sh   <= '0;
            r_bcd  <= '0;
            r_dig  <= {8{SEG_BLANK}};
            r_done <= 1'b0;
        end else begin
            r_page <= w_page;
            r_done <= 1'b0;
            if (w_chg || r_state == S_LOAD) begin
                r_idx <= w_load_idx;
                r_val <= w_field;
                r_sh  <= w_field;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                {r_bcd, r_sh} <= {w_adj[6:0], r_sh, 1'b0};
                r_cnt         <= r_cnt + 1'b1;
            end else if (r_state == S_STORE) begin
                r_dig[{r_idx, 1'b1}] <= w_tens;
                r_dig[{r_idx, 1'b0}] <= w_units;
                r_idx                <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                r_done               <= (r_idx == LAST);
            end
            if (w_chg)
                r_dig <= {8{SEG_BLANK}};
        end
    end

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset) begin
            r_blk_s1 <= 1'b0;
            r_blk    <= 1'b0;
        end else begin
            r_blk_s1 <= clock_4Hz;
            r_blk    <= r_blk_s1;
        end
    end

    // The AM/PM marker pair follows the hour select.
    always_comb begin
        w_blink_en   = 1'b0;
        w_pair_blink = '0;
        case (r_page)
            PG_CLOCK: begin
                w_blink_en   = set[0];
                w_pair_blink = {select[0], select[0], select[1], select[2]};
            end
            PG_DATE: begin
                w_blink_en   = set[1];
                w_pair_blink = {4{select[7]}}
                             | {select[3], select[4], select[5], select[6]};
            end
            PG_DSET: begin
                w_blink_en   = set[2];
                w_pair_blink = {4{select[12]}}
                             | {select[8], select[9], select[10], select[11]};
            end
            default: begin
                w_blink_en   = 1'b0;
                w_pair_blink = '0;
            end
        endcase
        w_blink_en = w_blink_en & ~r_blk;
    end

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset) begin
            r_hex <= {8{SEG_BLANK}};
        end else begin
            for (int d = 0; d < 8; d++) begin
                if (w_chg || (w_blink_en && w_pair_blink[d/2]))
                    r_hex[d] <= SEG_BLANK;
                else
                    r_hex[d] <= r_dig[d];
            end
        end
    end

    assign hex7         = r_hex[7];
    assign hex6         = r_hex[6];
    assign hex5         = r_hex[5];
    assign hex4         = r_hex[4];
    assign hex3         = r_hex[3];
    assign hex2         = r_hex[2];
    assign hex1         = r_hex[1];
    assign hex0         = r_hex[0];
    assign refresh_done = r_done;

endmodule

// File: tb/tb_output_module.sv
// tb_output_module: directed checks of the calendar display back-end.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_output_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c4;
    logic [2:0]  set;
    logic [12:0] sel;
    logic        ampm;
    logic        pm;
    logic [20:0] cf;
    logic [27:0] df;
    logic [27:0] dsf;
    logic [6:0]  h7, h6, h5, h4, h3, h2, h1, h0;
    logic        done;
    logic [55:0] all_hex;
    logic [55:0] exp_clk;
    logic [55:0] exp_date;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    assign all_hex = {h7, h6, h5, h4, h3, h2, h1, h0};

    output_module dut (
        .clock_50MHz  (clk),
        .reset        (rst_n),
        .clock_4Hz    (c4),
        .set          (set),
        .select       (sel),
        .mode_ampm    (ampm),
        .pm           (pm),
        .clock_fields (cf),
        .date_fields  (df),
        .dset_fields  (dsf),
        .hex7         (h7),
        .hex6         (h6),
        .hex5         (h5),
        .hex4         (h4),
        .hex3         (h3),
        .hex2         (h2),
        .hex1         (h1),
        .hex0         (h0),
        .refresh_done (done)
    );

    task automatic chk(input string tag, input logic [55:0] obs,
                       input logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++)
            cyc(1);
        chk(tag, done, 1);
    endtask

    task automatic wait_hex(input string tag, input logic [55:0] exp,
                            input int budget);
        for (int i = 0; i < budget && all_hex !== exp; i++)
            cyc(1);
        chk(tag, all_hex, exp);
    endtask

    function automatic logic [20:0] clkf(input int h, input int m,
                                         input int s);
        return {7'(h), 7'(m), 7'(s)};
    endfunction

    initial begin
        rst_n    = 1'b0;
        c4       = 1'b0;
        set      = 3'b000;
        sel      = '0;
        ampm     = 1'b0;
        pm       = 1'b0;
        cf       = clkf(12, 34, 56);
        df       = '0;
        dsf      = '0;
        exp_clk  = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        exp_date = {7'h24, 7'h40, 7'h24, 7'h19, 7'h40, 7'h78, 7'h79, 7'h12};

        cyc(3);
        chk("reset_hex", all_hex, {8{7'h7F}});
        chk("reset_done", done, 0);

        rst_n = 1'b1;
        cyc(35);
        chk("done_before_36", done, 0);
        cyc(1);
        chk("done_at_36", done, 1);
        cyc(1);
        chk("clock_page", all_hex, exp_clk);
        chk("done_one_cycle", done, 0);
        cyc(34);
        chk("done_before_72", done, 0);
        cyc(1);
        chk("done_at_72", done, 1);

        cf = clkf(12, 34, 100);
        cyc(80);
        chk("sec_over_99", {h1, h0}, {7'h3F, 7'h3F});
        cf = clkf(12, 34, 0);
        cyc(80);
        chk("sec_zero", {h1, h0}, {7'h40, 7'h40});
        cf = clkf(12, 34, 56);
        cyc(80);
        chk("clock_restored", all_hex, exp_clk);

        set = 3'b001;
        sel = 13'b0_0000_0000_0010;
        cyc(3);
        chk("blink_min_off", all_hex,
            {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02});
        c4 = 1'b1;
        cyc(2);
        chk("blink_sync_delay", {h3, h2}, {7'h7F, 7'h7F});
        cyc(1);
        chk("blink_min_on", all_hex, exp_clk);
        sel = '0;

        cyc(10);
        df  = {7'd20, 7'd24, 7'd7, 7'd15};
        set = 3'b010;
        cyc(1);
        chk("page_chg_blank", all_hex, {8{7'h7F}});
        wait_hex("date_page", exp_date, 40);

        sel = 13'h0080;
        c4  = 1'b0;
        cyc(3);
        chk("date_blink_all", all_hex, {8{7'h7F}});
        c4 = 1'b1;
        cyc(3);
        chk("date_blink_on", all_hex, exp_date);
        sel = 13'h1000;
        c4  = 1'b0;
        cyc(3);
        chk("dset_sel_no_effect", all_hex, exp_date);
        sel = '0;
        c4  = 1'b1;

        set  = 3'b000;
        ampm = 1'b1;
        pm   = 1'b1;
        cyc(80);
        chk("pm_marker", all_hex,
            {7'h0C, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        pm = 1'b0;
        cyc(80);
        chk("am_marker", {h7, h6}, {7'h08, 7'h7F});

        set = 3'b001;
        sel = 13'b0_0000_0000_0001;
        c4  = 1'b0;
        cyc(3);
        chk("hour_ampm_blink", all_hex,
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h19, 7'h12, 7'h02});
        set = 3'b000;
        cyc(3);
        chk("no_blink_set_off", all_hex,
            {7'h08, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        sel = '0;
        c4  = 1'b1;

        set = 3'b010;
        cyc(1);
        wait_done("date_refresh", 80);
        cyc(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_hex", all_hex, {8{7'h7F}});
        chk("async_reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(35);
        chk("rst_done_before_36", done, 0);
        cyc(1);
        chk("rst_done_at_36", done, 1);
        cyc(1);
        chk("date_after_reset", all_hex, exp_date);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
